// File: rtl/img2axis.sv
// Raw pixel stream to AXI4-Stream video master: tags each pixel with SOF/EOL
// from input coordinates and buffers it in a first-word fall-through FIFO.
module img2axis #(
   parameter int IMG_WIDTH  = 24,
   parameter int H_ACTIVE   = 512,
   parameter int V_ACTIVE   = 512,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [IMG_WIDTH-1:0] img_din,
   input  logic                 img_din_vld,
   output logic [IMG_WIDTH-1:0] m_axis_tdata,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic                 m_axis_tuser,
   output logic                 m_axis_tlast,
   output logic                 fifo_ovf,
   output logic                 frame_done
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
   localparam int EW = IMG_WIDTH + 2;

   logic [AW:0]    wptr_q, wptr_d, rptr_q, rptr_d, count;
   logic [XW-1:0]  x_q, x_d;
   logic [YW-1:0]  y_q, y_d, oline_q, oline_d;
   logic           ovf_q, ovf_d, fd_q, fd_d;
   logic [EW-1:0]  mem_q [FIFO_DEPTH];
   logic [EW-1:0]  wr_entry, head;
   logic           full, push, pop, sof, eol;

   always_comb begin
      count    = wptr_q - rptr_q;
      full     = (count == (AW+1)'(FIFO_DEPTH));
      head     = mem_q[rptr_q[AW-1:0]];
      m_axis_tvalid = (count != '0);
      pop      = m_axis_tvalid && m_axis_tready;
      // A full FIFO still accepts a pixel when the head leaves in the same cycle.
      push     = img_din_vld && (!full || pop);
      sof      = (x_q == '0) && (y_q == '0);
      eol      = (x_q == XW'(H_ACTIVE - 1));
      wr_entry = {sof, eol, img_din};

      // Head is masked while empty so outputs read zero out of reset.
      m_axis_tdata = m_axis_tvalid ? head[IMG_WIDTH-1:0] : '0;
      m_axis_tlast = m_axis_tvalid && head[IMG_WIDTH];
      m_axis_tuser = m_axis_tvalid && head[IMG_WIDTH+1];

      wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
      rptr_d  = pop  ? rptr_q + 1'b1 : rptr_q;
      ovf_d   = ovf_q || (img_din_vld && !push);

      // Coordinates track every input beat, dropped or not, to keep frame alignment.
      x_d = x_q;
      y_d = y_q;
      if (img_din_vld) begin
         if (eol) begin
            x_d = '0;
            y_d = (y_q == YW'(V_ACTIVE - 1)) ? '0 : y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
      end

      oline_d = oline_q;
      fd_d    = 1'b0;
      if (pop && head[IMG_WIDTH]) begin
         if (oline_q == YW'(V_ACTIVE - 1)) begin
            oline_d = '0;
            fd_d    = 1'b1;
         end else begin
            oline_d = oline_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         x_q     <= '0;
         y_q     <= '0;
         oline_q <= '0;
         ovf_q   <= 1'b0;
         fd_q    <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         x_q     <= x_d;
         y_q     <= y_d;
         oline_q <= oline_d;
         ovf_q   <= ovf_d;
         fd_q    <= fd_d;
      end
   end

   // Storage needs no reset: entries are only visible once written.
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q[AW-1:0]] <= wr_entry;
   end

   assign fifo_ovf   = ovf_q;
   assign frame_done = fd_q;

endmodule
